// File: rtl/imem_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// imem_sync : instruction memory with registered ready/valid fetch port and a
//             byte-strobed load port. Optional stored parity: IMEM_PARITY_EN.
// Revision  : 1.0
// ============================================================================
module imem_sync #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic                  rd_ready_o,
    output logic                  rd_valid_o,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_fault_o,
    output logic                  rd_perr_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W/8-1:0]   wr_be_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    output logic                  wr_fault_o,
    input  logic                  par_inj_i
);

    localparam int c_bytes  = DATA_W / 8;
    localparam int c_off_w  = (c_bytes > 1) ? $clog2(c_bytes) : 0;
    localparam int c_mem_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
    localparam int c_store_w = DATA_W + 1;
`else
    localparam int c_store_w = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] c_off_mask = ADDR_W'((1 << c_off_w) - 1);
    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]        c_cnt_init = 2'((READ_LAT > 1) ? READ_LAT - 2 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [c_store_w-1:0] mem_q [DEPTH];

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic                pend_fault_q, pend_fault_d;
    logic                pend_perr_q, pend_perr_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_fault_q, rd_fault_d;
    logic                rd_perr_q, rd_perr_d;
    logic                wr_fault_q, wr_fault_d;

    logic [ADDR_W-1:0]    w_rd_idx;
    logic                 w_rd_bad;
    logic [c_store_w-1:0] w_rd_word;
    logic [DATA_W-1:0]    w_rd_data;
    logic                 w_rd_perr;
    logic                 w_accept;

    logic [ADDR_W-1:0]    w_wr_idx;
    logic                 w_wr_bad;
    logic                 w_wr_ok;
    logic [DATA_W-1:0]    w_wr_old;
    logic [DATA_W-1:0]    w_wr_merged;
    logic [c_store_w-1:0] w_wr_word;

    // Fetch-side decode; the array is sampled combinationally so a same-edge
    // write to the same word is seen by the read as its pre-write contents.
    always_comb begin
        w_rd_idx  = rd_addr_i >> c_off_w;
        w_rd_bad  = ((rd_addr_i & c_off_mask) != '0) || ({1'b0, w_rd_idx} >= c_depth);
        w_rd_word = mem_q[w_rd_idx[c_mem_aw-1:0]];
        w_rd_data = w_rd_bad ? '0 : w_rd_word[DATA_W-1:0];
`ifdef IMEM_PARITY_EN
        w_rd_perr = !w_rd_bad && (^w_rd_word);
`else
        w_rd_perr = 1'b0;
`endif
    end

    always_comb begin
        w_wr_idx    = wr_addr_i >> c_off_w;
        w_wr_bad    = ((wr_addr_i & c_off_mask) != '0) || ({1'b0, w_wr_idx} >= c_depth);
        w_wr_ok     = wr_en_i && !w_wr_bad;
        w_wr_old    = mem_q[w_wr_idx[c_mem_aw-1:0]][DATA_W-1:0];
        w_wr_merged = w_wr_old;
        for (int b = 0; b < c_bytes; b++) begin
            if (wr_be_i[b]) begin
                w_wr_merged[b*8 +: 8] = wr_data_i[b*8 +: 8];
            end
        end
`ifdef IMEM_PARITY_EN
        // Parity covers the whole merged word so partial writes stay consistent.
        w_wr_word = {(^w_wr_merged) ^ par_inj_i, w_wr_merged};
`else
        w_wr_word = w_wr_merged;
`endif
    end

`ifndef IMEM_PARITY_EN
    logic w_unused_par;
    assign w_unused_par = par_inj_i;
`endif

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            mem_q[w_wr_idx[c_mem_aw-1:0]] <= w_wr_word;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_data_d  = pend_data_q;
        pend_fault_d = pend_fault_q;
        pend_perr_d  = pend_perr_q;
        rd_data_d    = rd_data_q;
        rd_fault_d   = rd_fault_q;
        rd_perr_d    = rd_perr_q;
        wr_fault_d   = wr_en_i && w_wr_bad;
        w_accept     = 1'b0;

        case (state_q)
            IDLE, RESP: begin
                if (rd_req_i) begin
                    w_accept = 1'b1;
                    state_d  = (READ_LAT == 1) ? RESP : WAIT;
                    cnt_d    = c_cnt_init;
                end else begin
                    state_d  = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d    = RESP;
                    rd_data_d  = pend_data_q;
                    rd_fault_d = pend_fault_q;
                    rd_perr_d  = pend_perr_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_accept) begin
            pend_data_d  = w_rd_data;
            pend_fault_d = w_rd_bad;
            pend_perr_d  = w_rd_perr;
            // Single-cycle latency enters RESP on the accept edge itself.
            if (READ_LAT == 1) begin
                rd_data_d  = w_rd_data;
                rd_fault_d = w_rd_bad;
                rd_perr_d  = w_rd_perr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            pend_data_q  <= '0;
            pend_fault_q <= 1'b0;
            pend_perr_q  <= 1'b0;
            rd_data_q    <= '0;
            rd_fault_q   <= 1'b0;
            rd_perr_q    <= 1'b0;
            wr_fault_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_data_q  <= pend_data_d;
            pend_fault_q <= pend_fault_d;
            pend_perr_q  <= pend_perr_d;
            rd_data_q    <= rd_data_d;
            rd_fault_q   <= rd_fault_d;
            rd_perr_q    <= rd_perr_d;
            wr_fault_q   <= wr_fault_d;
        end
    end

    assign rd_ready_o = (state_q != WAIT);
    assign rd_valid_o = (state_q == RESP);
    assign rd_data_o  = rd_data_q;
    assign rd_fault_o = rd_fault_q;
    assign rd_perr_o  = rd_perr_q;
    assign wr_fault_o = wr_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_imem_sync : self-checking bench for imem_sync (READ_LAT=1 and READ_LAT=3).
// Revision     : 1.0
// ============================================================================
module tb_imem_sync;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rd_req;
    logic [8:0]  rd_addr;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        par_inj;

    logic        rdy1, vld1, flt1, perr1, wflt1;
    logic [31:0] dat1;
    logic        rdy3, vld3, flt3, perr3, wflt3;
    logic [31:0] dat3;

    imem_sync #(.DATA_W(32), .DEPTH(64), .ADDR_W(9), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(rdy1),
        .rd_valid_o(vld1), .rd_data_o(dat1), .rd_fault_o(flt1), .rd_perr_o(perr1),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
        .wr_fault_o(wflt1), .par_inj_i(par_inj)
    );

    imem_sync #(.DATA_W(32), .DEPTH(64), .ADDR_W(9), .READ_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(rdy3),
        .rd_valid_o(vld3), .rd_data_o(dat3), .rd_fault_o(flt3), .rd_perr_o(perr3),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
        .wr_fault_o(wflt3), .par_inj_i(par_inj)
    );

`ifdef IMEM_PARITY_EN
    localparam logic c_par = 1'b1;
`else
    localparam logic c_par = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
        logic        perr;
    } exp_t;

    typedef struct {
        logic [8:0] addr;
        exp_t       exp;
    } rd_vec_t;

    typedef struct {
        logic [8:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        inj;
        logic        exp_fault;
    } wr_vec_t;

    int      checks = 0;
    int      errors = 0;
    exp_t    sb_q[$];
    exp_t    cur_exp;
    logic    mon_en = 1'b0;
    rd_vec_t rv[10];
    wr_vec_t wv[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard for the READ_LAT=1 instance: push on accept, pop on valid.
    always @(posedge clk) begin
        logic acc;
        exp_t e;
        acc = mon_en && rd_req && rdy1;
        if (acc) sb_q.push_back(cur_exp);
        if (mon_en) begin
            #1;
            check("lat1_valid", 32'(vld1), 32'(acc));
            check("lat1_ready", 32'(rdy1), 32'd1);
            if (vld1) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("rd_data", dat1, e.data);
                    check("rd_fault", 32'(flt1), 32'(e.fault));
                    check("rd_perr", 32'(perr1), 32'(e.perr));
                end
            end
        end
    end

    task automatic do_write(input logic [8:0] a, input logic [3:0] be, input logic [31:0] d,
                            input logic inj, input logic exp_fault);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_be   = be;
        wr_data = d;
        par_inj = inj;
        @(posedge clk);
        #1;
        check("wr_fault", 32'(wflt1), 32'(exp_fault));
        @(negedge clk);
        wr_en   = 1'b0;
        par_inj = 1'b0;
    endtask

    task automatic read1(input logic [8:0] a, input exp_t e);
        rd_req  = 1'b1;
        rd_addr = a;
        cur_exp = e;
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wv[0] = '{9'h000, 4'hF, 32'h00102083, 1'b0, 1'b0};
        wv[1] = '{9'h004, 4'hF, 32'h11111111, 1'b0, 1'b0};
        wv[2] = '{9'h004, 4'h5, 32'hAABBCCDD, 1'b0, 1'b0};
        wv[3] = '{9'h008, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0};
        wv[4] = '{9'h00A, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b1};
        wv[5] = '{9'h00C, 4'hF, 32'h0BADF00D, 1'b0, 1'b0};
        wv[6] = '{9'h102, 4'hF, 32'h99999999, 1'b0, 1'b1};
        wv[7] = '{9'h100, 4'hF, 32'h55555555, 1'b0, 1'b1};
        wv[8] = '{9'h0FC, 4'hF, 32'hCAFEBABE, 1'b0, 1'b0};
        wv[9] = '{9'h010, 4'hF, 32'h12345678, 1'b1, 1'b0};

        rv[0] = '{9'h000, '{32'h00102083, 1'b0, 1'b0}};
        rv[1] = '{9'h004, '{32'h11BB11DD, 1'b0, 1'b0}};
        rv[2] = '{9'h006, '{32'h00000000, 1'b1, 1'b0}};
        rv[3] = '{9'h100, '{32'h00000000, 1'b1, 1'b0}};
        rv[4] = '{9'h008, '{32'hDEADBEEF, 1'b0, 1'b0}};
        rv[5] = '{9'h00C, '{32'h0BADF00D, 1'b0, 1'b0}};
        rv[6] = '{9'h010, '{32'h12345678, 1'b0, c_par}};
        rv[7] = '{9'h012, '{32'h00000000, 1'b1, 1'b0}};
        rv[8] = '{9'h102, '{32'h00000000, 1'b1, 1'b0}};
        rv[9] = '{9'h0FC, '{32'hCAFEBABE, 1'b0, 1'b0}};

        rst_n   = 1'b0;
        rd_req  = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_be   = '0;
        wr_data = '0;
        par_inj = 1'b0;
        cur_exp = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(vld1), 32'd0);
        check("rst_data", dat1, 32'd0);
        check("rst_fault", 32'(flt1), 32'd0);
        check("rst_perr", 32'(perr1), 32'd0);
        check("rst_wr_fault", 32'(wflt1), 32'd0);
        check("rst_ready", 32'(rdy1), 32'd1);
        check("rst_ready3", 32'(rdy3), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_write(wv[i].addr, wv[i].be, wv[i].data, wv[i].inj, wv[i].exp_fault);
        end

        // Back-to-back fetch stream, one request per cycle.
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd_req  = 1'b1;
            rd_addr = rv[i].addr;
            cur_exp = rv[i].exp;
            @(negedge clk);
        end
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_data", dat1, 32'hCAFEBABE);
        check("hold_fault", 32'(flt1), 32'd0);

        // Clean parity rewrite, then read-first collision on word 0x0C.
        do_write(9'h010, 4'hF, 32'h12345678, 1'b0, 1'b0);
        read1(9'h010, '{32'h12345678, 1'b0, 1'b0});
        rd_req  = 1'b1;
        rd_addr = 9'h00C;
        cur_exp = '{32'h0BADF00D, 1'b0, 1'b0};
        wr_en   = 1'b1;
        wr_addr = 9'h00C;
        wr_be   = 4'hF;
        wr_data = 32'h12121212;
        @(negedge clk);
        rd_req = 1'b0;
        wr_en  = 1'b0;
        read1(9'h00C, '{32'h12121212, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        mon_en = 1'b0;
        repeat (6) @(negedge clk);

        // READ_LAT=3 latency and ready behaviour.
        rd_req  = 1'b1;
        rd_addr = 9'h008;
        #1;
        check("l3_idle_ready", 32'(rdy3), 32'd1);
        @(posedge clk);
        #1;
        check("l3_wait_ready", 32'(rdy3), 32'd0);
        check("l3_wait_valid0", 32'(vld3), 32'd0);
        @(negedge clk);
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        check("l3_wait_valid1", 32'(vld3), 32'd0);
        check("l3_wait_ready1", 32'(rdy3), 32'd0);
        @(posedge clk);
        #1;
        check("l3_resp_valid", 32'(vld3), 32'd1);
        check("l3_resp_data", dat3, 32'hDEADBEEF);
        check("l3_resp_fault", 32'(flt3), 32'd0);
        @(posedge clk);
        #1;
        check("l3_after_valid", 32'(vld3), 32'd0);
        check("l3_after_ready", 32'(rdy3), 32'd1);
        check("l3_after_data", dat3, 32'hDEADBEEF);

        // Reset one cycle after accepting a READ_LAT=3 read drops it.
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = 9'h00C;
        @(negedge clk);
        rd_req = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("l3_rst_valid", 32'(vld3), 32'd0);
        check("l3_rst_data", dat3, 32'd0);
        check("l3_rst_fault", 32'(flt3), 32'd0);
        check("l3_rst_perr", 32'(perr3), 32'd0);
        check("l3_rst_wr_fault", 32'(wflt3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("l3_post_rst_valid", 32'(vld3), 32'd0);
            check("l3_post_rst_ready", 32'(rdy3), 32'd1);
            check("l3_post_rst_data", dat3, 32'd0);
        end

        // Memory contents survive reset.
        @(negedge clk);
        mon_en = 1'b1;
        read1(9'h000, '{32'h00102083, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        check("sb_empty_end", 32'(sb_q.size()), 32'd0);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_sync.md
Name: imem_sync

Overview:
- Parametrised instruction memory for the RISC-V core; successor to the fixed 64x32 combinational ROM.
- Byte-addressed fetch port with registered read and configurable latency. Handshake is ready/valid.
- Includes a byte-strobed load port so programs can be written at run time instead of hard-coded.
- Flags misaligned and out-of-range accesses.

Parameters:
- DATA_W, 32: word width in bits; multiple of 8.
- DEPTH, 64: number of words.
- ADDR_W, 8: byte-address width; must satisfy 2^ADDR_W >= DEPTH*DATA_W/8.
- READ_LAT, 1: cycles from request accept to response; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req_i  in  1  fetch request valid.
- rd_addr_i  in  ADDR_W  fetch byte address.
- rd_ready_o  out  1  request can be accepted this cycle.
- rd_valid_o  out  1  response valid; one-cycle pulse.
- rd_data_o  out  DATA_W  fetched word.
- rd_fault_o  out  1  response is a fault (misaligned or out of range).
- rd_perr_o  out  1  parity error on response (see Optional Feature).
- wr_en_i  in  1  load-port write strobe.
- wr_addr_i  in  ADDR_W  load byte address.
- wr_be_i  in  DATA_W/8  byte enables.
- wr_data_i  in  DATA_W  load data.
- wr_fault_o  out  1  registered pulse: last write was rejected.
- par_inj_i  in  1  invert stored parity on this write (test only).

Behaviour:
- Address decode: word index = addr >> log2(DATA_W/8).
  - Misaligned: any of the low log2(DATA_W/8) address bits nonzero.
  - Out of range: index >= DEPTH.
- Reset (async, rst_n=0): FSM to IDLE; rd_valid_o=0, rd_data_o=0, rd_fault_o=0, rd_perr_o=0, wr_fault_o=0; rd_ready_o=1 once in IDLE.
  - Memory array is not cleared.
  - Reset during a pending read drops it; no rd_valid_o follows.
- FSM states IDLE, WAIT, RESP:
  - Accept occurs on an edge where rd_req_i=1 and rd_ready_o=1. The array is read at that edge and the address is fault-checked at that edge.
  - READ_LAT=1: accept -> RESP.
  - READ_LAT>1: accept -> WAIT; a down-counter is loaded with READ_LAT-2; WAIT -> RESP when the counter reaches 0.
  - RESP: rd_valid_o=1 for exactly one cycle.
    - If rd_req_i=1 in RESP, it is accepted: next state is RESP (READ_LAT=1) or WAIT.
    - Otherwise RESP -> IDLE.
- rd_ready_o = 1 in IDLE and RESP, 0 in WAIT. READ_LAT=1 therefore gives one fetch per cycle.
- rd_data_o and rd_fault_o update only when entering RESP and hold until the next response.
  - On a fault: rd_data_o=0, rd_fault_o=1, same latency as a normal read.
- Load port:
  - Independent of the FSM; accepted every cycle wr_en_i=1.
  - Only bytes with wr_be_i set are updated.
  - A misaligned or out-of-range write leaves memory unchanged and sets wr_fault_o=1 for one cycle; otherwise wr_fault_o=0 the next cycle.
- Simultaneous read accept and write to the same word: read-first. The response carries the pre-write data.
- rd_req_i deasserted while rd_ready_o=0 has no effect. The in-flight read completes.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores DATA_W+1 bits; the extra bit is even parity of the full post-write word, recomputed on every write, including partial byte-enable writes.
  - par_inj_i=1 stores the inverted parity.
  - Parity is checked on read; a mismatch sets rd_perr_o=1 with rd_valid_o.
  - Fault responses force rd_perr_o=0.
- Undefined: storage is DATA_W bits, par_inj_i is ignored, rd_perr_o is tied 0.

Test Plan:
- READ_LAT=1: write 0x00102083, be=0xF, addr 0x00; then read 0x00 -> rd_valid_o one cycle after accept, rd_data_o=0x00102083, rd_fault_o=0.
- Word 0x04 holds 0x11111111; write 0xAABBCCDD with be=4'b0101 to 0x04; read 0x04 -> rd_data_o=0x11BB11DD.
- Read 0x06 -> rd_fault_o=1, rd_data_o=0. With ADDR_W=9, read 0x100 -> rd_fault_o=1. Write to 0x102 -> wr_fault_o pulses 1, memory unchanged.
- READ_LAT=1: back-to-back requests to 0x04, 0x08, 0x0C -> rd_valid_o high three consecutive cycles with matching data, rd_ready_o never low.
- READ_LAT=3: accept read of 0x08, assert rst_n=0 one cycle later -> no rd_valid_o, all outputs 0, rd_ready_o=1 after release.
- IMEM_PARITY_EN: write 0x12345678 with par_inj_i=1 to 0x10, read 0x10 -> rd_perr_o=1, data 0x12345678. Rewrite with par_inj_i=0 -> rd_perr_o=0.
